arith_mult_karatsuba_arb: RTL and testbench
===========================================

# arith_mult_karatsuba_arb

Round-robin arbiter that shares one pipelined Karatsuba multiplier between NB_REQ requesters. It accepts operand pairs over valid/ready, drives the multiplier input, and tracks each requester's id alongside the multiplier pipeline. It returns each product only to the requester that issued it. It sits between the NTT/modular-arithmetic clients and a single multiplier instance, and supports locked multi-beat bursts.

## Interface
- OP_W, 64, operand width; product is 2*OP_W.
- NB_REQ, 4, number of requesters, 2..16.
- MULT_LATENCY, 5, multiplier latency in cycles (input avail to output avail); the parent sets it from the multiplier package latency function.
- ID_W, $clog2(NB_REQ), internal id width (localparam).

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  synchronous active-low reset.
- req_a  in  NB_REQ*OP_W  operand A per requester.
- req_b  in  NB_REQ*OP_W  operand B per requester.
- req_last  in  NB_REQ  last beat of a burst; 1 = single beat.
- req_vld  in  NB_REQ  request valid.
- req_rdy  out  NB_REQ  request ready; one-hot or zero.
- mult_a  out  OP_W  multiplier operand A.
- mult_b  out  OP_W  multiplier operand B.
- mult_avail  out  1  multiplier input valid.
- mult_z  in  2*OP_W  multiplier product.
- mult_z_avail  in  1  multiplier output valid.
- rsp_z  out  2*OP_W  product returned to a requester.
- rsp_avail  out  NB_REQ  one-hot response valid; there is no backpressure.
- busy  out  1  pipeline holds in-flight ops, or state is LOCK.
- err_seq  out  1  one-cycle pulse when mult_z_avail and the tracker tail disagree.

## Operation
- State machine has two states, ARB and LOCK. Both reset to ARB.
- ARB state:
  - grant = first req_vld[i] searching from ptr+1 upward, wrapping modulo NB_REQ.
  - req_rdy = onehot(grant). req_rdy is combinational from req_vld; req_rdy never depends on mult_z_avail.
- Accept = req_vld[g] & req_rdy[g].
  - In ARB: if req_last[g]=1, stay in ARB and set ptr←g.
  - In ARB: if req_last[g]=0, go to LOCK with owner←g.
- LOCK state:
  - req_rdy = onehot(owner) only; every other req_vld is ignored.
  - An accepted beat with req_last=1 returns to ARB and sets ptr←owner.
  - An owner vld low does not release the lock.
- Reset values: ptr = NB_REQ-1, so requester 0 wins first.
- Each accepted beat registers {req_a[g], req_b[g]} into mult_a/mult_b, with mult_avail=1 on the next cycle. Otherwise mult_avail=0 and mult_a/mult_b hold their value.
- Tracker: shift register of depth MULT_LATENCY carrying {vld, id}, advanced every cycle.
  - When mult_z_avail=1 and tail.vld=1: rsp_z←mult_z, rsp_avail←onehot(tail.id), both registered.
  - When mult_z_avail differs from tail.vld: err_seq pulses and no response is issued.
- Products pass through untouched; width is 2*OP_W and there is no truncation.
- Reset outputs:
  - req_rdy follows req_vld and is valid in the first cycle after reset.
  - mult_avail=0, rsp_avail=0, busy=0, err_seq=0.
  - mult_a, mult_b, rsp_z = 0.
  - All tracker vld bits = 0.
- Reset mid-operation: in-flight tracker entries and any lock are discarded. Products emerging afterwards are not forwarded. Such products raise err_seq only if mult_z_avail is asserted, and the multiplier shares s_rst_n, so this case is not normal.
- Simultaneous events: an accept and a tracker tail output in the same cycle are independent. Throughput is one op per cycle.

## Timing
- Accept at cycle t:
  - mult_avail at t+1.
  - mult_z_avail expected at t+1+MULT_LATENCY.
  - rsp_avail at t+2+MULT_LATENCY.
- End-to-end latency is MULT_LATENCY+2 without the macro (7 at default).
- busy is registered and is 1 while any tracker vld=1 or state=LOCK.
- Responses return in accept order; there is no reordering.

## Configuration
- ARITH_MULT_KARATSUBA_ARB_IN_PIPE_EN:
  - Defined: adds a register stage on mult_z/mult_z_avail and one extra tracker stage (depth MULT_LATENCY+1). End-to-end latency becomes MULT_LATENCY+3.
  - Undefined: mult_z feeds the response register directly.

## Test plan
- Single request: requester 2, a=3, b=5, last=1 at t. Expect mult_avail at t+1, rsp_avail=4'b0100 with rsp_z=15 at t+7, then busy=0 at t+8.
- All four vld high, all last=1, held for 8 cycles. Expect grants 0,1,2,3,0,1,2,3, one per cycle, and responses in the same order 7 cycles later.
- Burst: requester 1 sends 3 beats (last on beat 3) while 0 and 3 are valid. Expect req_rdy only for 1 for 3 accepts, then grant goes to 3 (search from ptr=1 upward), then 0.
- Lock with gap: owner drops vld for 2 cycles mid-burst. Expect req_rdy stays on the owner and other requesters get no grant.
- Max operands: a=b=2^64-1. Expect rsp_z=2^128-2^65+1.
- Error/reset: inject mult_z_avail with the tracker empty. Expect a one-cycle err_seq pulse and no rsp_avail. Assert s_rst_n=0 with 3 ops in flight. Expect all responses suppressed and ptr returned to 3.

Source files
------------

// File: rtl/arith_mult_karatsuba_arb.sv
// -----------------------------------------------------------------------------
// arith_mult_karatsuba_arb
//
// Round-robin arbiter that shares one pipelined Karatsuba multiplier between
// NB_REQ requesters. It accepts operand pairs, drives the multiplier input and
// carries each requester's id along a tracker that matches the multiplier
// pipeline depth. Each product goes back only to the requester that issued it.
// Multi-beat bursts lock the arbiter onto one requester until the last beat.
//
// Handshake: a beat from requester i transfers in any cycle where
// req_vld[i] & req_rdy[i] is high. req_rdy is one-hot or zero. It depends
// combinationally on req_vld and never on the multiplier output. Responses
// (rsp_avail) have no backpressure.
//
// Parameters:
//   OP_W         operand width; the product is 2*OP_W bits.
//   NB_REQ       number of requesters (2..16).
//   MULT_LATENCY multiplier latency, from input avail to output avail.
//
// Ports:
//   clk, s_rst_n            clock, synchronous active-low reset
//   req_a, req_b            operands per requester (NB_REQ*OP_W each)
//   req_last                last beat of a burst (1 = single beat)
//   req_vld / req_rdy       request handshake per requester
//   mult_a, mult_b          registered multiplier operands
//   mult_avail              multiplier input valid
//   mult_z, mult_z_avail    multiplier product and product valid
//   rsp_z, rsp_avail        registered product and one-hot destination
//   busy                    ops in flight or arbiter locked (registered)
//   err_seq                 pulse when mult_z_avail disagrees with the tracker
//
// Optional feature macro: ARITH_MULT_KARATSUBA_ARB_IN_PIPE_EN
//   When defined, mult_z/mult_z_avail are registered before use and the
//   tracker grows by one stage. End-to-end latency is MULT_LATENCY+3
//   instead of MULT_LATENCY+2.
// -----------------------------------------------------------------------------
module arith_mult_karatsuba_arb #(
    parameter int OP_W         = 64,
    parameter int NB_REQ       = 4,
    parameter int MULT_LATENCY = 5
) (
    input  logic                     clk,
    input  logic                     s_rst_n,
    input  logic [NB_REQ*OP_W-1:0]   req_a,
    input  logic [NB_REQ*OP_W-1:0]   req_b,
    input  logic [NB_REQ-1:0]        req_last,
    input  logic [NB_REQ-1:0]        req_vld,
    output logic [NB_REQ-1:0]        req_rdy,
    output logic [OP_W-1:0]          mult_a,
    output logic [OP_W-1:0]          mult_b,
    output logic                     mult_avail,
    input  logic [2*OP_W-1:0]        mult_z,
    input  logic                     mult_z_avail,
    output logic [2*OP_W-1:0]        rsp_z,
    output logic [NB_REQ-1:0]        rsp_avail,
    output logic                     busy,
    output logic                     err_seq
);

    localparam int ID_W = $clog2(NB_REQ);

`ifdef ARITH_MULT_KARATSUBA_ARB_IN_PIPE_EN
    localparam int TRK_DEPTH = MULT_LATENCY + 1;
`else
    localparam int TRK_DEPTH = MULT_LATENCY;
`endif

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic logic [NB_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NB_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   cand;
    logic              grant_found;
    logic [ID_W-1:0]   sel;
    logic [NB_REQ-1:0] rdy;
    logic              accept;
    logic [OP_W-1:0]   a_sel, b_sel;
    logic              last_sel;
    logic [ID_W-1:0]   mult_id;

    logic [TRK_DEPTH-1:0] trk_vld;
    logic [ID_W-1:0]      trk_id [TRK_DEPTH];
    logic                 tail_vld;
    logic [ID_W-1:0]      tail_id;

    logic [2*OP_W-1:0]    z_src;
    logic                 z_avail;

    // Round-robin search: first valid requester starting at ptr+1, wrapping.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NB_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NB_REQ);
            if (!grant_found && req_vld[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    // Ready and selected requester. In LOCK the owner stays ready even when
    // its valid is low, so a gap in the burst does not release the lock.
    always_comb begin
        sel = grant;
        rdy = '0;
        case (state_q)
            ARB: begin
                sel = grant;
                if (grant_found) rdy = onehot(grant);
            end
            LOCK: begin
                sel = owner_q;
                rdy = onehot(owner_q);
            end
            default: begin
                sel = grant;
                rdy = '0;
            end
        endcase
    end

    assign req_rdy = rdy;
    assign accept  = |(req_vld & rdy);

    // Operand / last mux for the selected requester.
    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        last_sel = 1'b0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                a_sel    = req_a[i*OP_W +: OP_W];
                b_sel    = req_b[i*OP_W +: OP_W];
                last_sel = req_last[i];
            end
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (last_sel) begin
                state_d = ARB;
                ptr_d   = sel;
            end else begin
                state_d = LOCK;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q <= ARB;
            ptr_q   <= ID_W'(NB_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Multiplier input register; operands hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            mult_a     <= '0;
            mult_b     <= '0;
            mult_avail <= 1'b0;
            mult_id    <= '0;
        end else begin
            mult_avail <= accept;
            if (accept) begin
                mult_a  <= a_sel;
                mult_b  <= b_sel;
                mult_id <= sel;
            end
        end
    end

`ifdef ARITH_MULT_KARATSUBA_ARB_IN_PIPE_EN
    logic [2*OP_W-1:0] z_q;
    logic              z_avail_q;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            z_q       <= '0;
            z_avail_q <= 1'b0;
        end else begin
            z_q       <= mult_z;
            z_avail_q <= mult_z_avail;
        end
    end

    assign z_src   = z_q;
    assign z_avail = z_avail_q;
`else
    assign z_src   = mult_z;
    assign z_avail = mult_z_avail;
`endif

    // Tracker is fed from the registered multiplier input so its tail lines
    // up with the cycle the product is expected on z_avail.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            trk_vld <= '0;
            for (int i = 0; i < TRK_DEPTH; i++) trk_id[i] <= '0;
        end else begin
            trk_vld[0] <= mult_avail;
            trk_id[0]  <= mult_id;
            for (int i = 1; i < TRK_DEPTH; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_id[i]  <= trk_id[i-1];
            end
        end
    end

    assign tail_vld = trk_vld[TRK_DEPTH-1];
    assign tail_id  = trk_id[TRK_DEPTH-1];

    // Response, sequencing error and busy.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            rsp_z     <= '0;
            rsp_avail <= '0;
            err_seq   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_avail <= '0;
            err_seq   <= z_avail ^ tail_vld;
            if (z_avail && tail_vld) begin
                rsp_z     <= z_src;
                rsp_avail <= onehot(tail_id);
            end
            busy <= (state_q == LOCK) | accept | mult_avail | (|trk_vld);
        end
    end

endmodule

// File: tb/tb_arith_mult_karatsuba_arb.sv
module tb_arith_mult_karatsuba_arb;

    localparam int OP_W         = 64;
    localparam int NB_REQ       = 4;
    localparam int MULT_LATENCY = 5;
`ifdef ARITH_MULT_KARATSUBA_ARB_IN_PIPE_EN
    localparam int LAT = MULT_LATENCY + 3;
`else
    localparam int LAT = MULT_LATENCY + 2;
`endif
    localparam int W = NB_REQ + 2*OP_W;

    logic                   clk;
    logic                   s_rst_n;
    logic [NB_REQ*OP_W-1:0] req_a, req_b;
    logic [NB_REQ-1:0]      req_last, req_vld, req_rdy;
    logic [OP_W-1:0]        mult_a, mult_b;
    logic                   mult_avail;
    logic [2*OP_W-1:0]      mult_z;
    logic                   mult_z_avail;
    logic [2*OP_W-1:0]      rsp_z;
    logic [NB_REQ-1:0]      rsp_avail;
    logic                   busy, err_seq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic err_allowed;
    logic inj_avail;
    logic [2*OP_W-1:0] inj_z;

    arith_mult_karatsuba_arb #(
        .OP_W(OP_W), .NB_REQ(NB_REQ), .MULT_LATENCY(MULT_LATENCY)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .mult_a(mult_a), .mult_b(mult_b), .mult_avail(mult_avail),
        .mult_z(mult_z), .mult_z_avail(mult_z_avail),
        .rsp_z(rsp_z), .rsp_avail(rsp_avail),
        .busy(busy), .err_seq(err_seq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model (shares s_rst_n) ----------------
    logic [2*OP_W-1:0]       mp_z [MULT_LATENCY];
    logic [MULT_LATENCY-1:0] mp_v;

    always @(posedge clk) begin
        if (!s_rst_n) begin
            mp_v <= '0;
        end else begin
            mp_v[0] <= mult_avail;
            mp_z[0] <= {64'd0, mult_a} * {64'd0, mult_b};
            for (int i = 1; i < MULT_LATENCY; i++) begin
                mp_v[i] <= mp_v[i-1];
                mp_z[i] <= mp_z[i-1];
            end
        end
    end

    assign mult_z_avail = mp_v[MULT_LATENCY-1] | inj_avail;
    assign mult_z       = inj_avail ? inj_z : mp_z[MULT_LATENCY-1];

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [NB_REQ-1:0] acc;
        logic [2*OP_W-1:0] p;
        logic [W-1:0]      e;
        if (s_rst_n) begin
            acc = req_vld & req_rdy;
            if (acc != '0) begin
                check("accept_onehot", W'($countones(acc)), W'(1));
                for (int i = 0; i < NB_REQ; i++) begin
                    if (acc[i]) begin
                        p = {64'd0, req_a[i*OP_W +: OP_W]} * {64'd0, req_b[i*OP_W +: OP_W]};
                        e = '0;
                        e[2*OP_W + i] = 1'b1;
                        e[2*OP_W-1:0] = p;
                        exp_q.push_back(e);
                    end
                end
            end
            if (rsp_avail != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", W'(rsp_avail), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rsp_avail", W'(rsp_avail), W'(e[W-1:2*OP_W]));
                    check("sb_rsp_z", W'(rsp_z), W'(e[2*OP_W-1:0]));
                end
            end
            if (!err_allowed) check("no_err_seq", W'(err_seq), W'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s_rst_n = 1'b0;
        req_vld = '0;
        exp_q.delete();
        repeat (3) tick();
        s_rst_n = 1'b1;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NB_REQ; i++) begin
            req_a[i*OP_W +: OP_W] = {$urandom, $urandom};
            req_b[i*OP_W +: OP_W] = {$urandom, $urandom};
        end
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        check("queue_drained", W'(exp_q.size()), W'(0));
    endtask

    typedef struct packed {
        logic [1:0]        id;
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        logic [2*OP_W-1:0] z;
    } vec_t;

    typedef struct packed {
        logic [NB_REQ-1:0] vld;
        logic [NB_REQ-1:0] last;
        logic [NB_REQ-1:0] rdy;
    } step_t;

    vec_t  vecs[6];
    step_t steps[16];

    task automatic run_single(input vec_t v);
        logic [NB_REQ-1:0] oh;
        int k;
        logic found;
        oh = '0;
        oh[v.id] = 1'b1;
        randomize_ops();
        req_a[int'(v.id)*OP_W +: OP_W] = v.a;
        req_b[int'(v.id)*OP_W +: OP_W] = v.b;
        req_last = '1;
        req_vld  = oh;
        @(negedge clk);
        check("single_rdy", W'(req_rdy), W'(oh));
        tick();
        req_vld = '0;
        @(negedge clk);
        check("single_mult_avail", W'(mult_avail), W'(1));
        check("single_mult_a", W'(mult_a), W'(v.a));
        check("single_mult_b", W'(mult_b), W'(v.b));
        k = 1;
        found = 1'b0;
        while (!found && k < 20) begin
            @(negedge clk);
            k++;
            if (rsp_avail != '0) found = 1'b1;
        end
        check("single_latency", W'(k), W'(LAT));
        check("single_rsp_avail", W'(rsp_avail), W'(oh));
        check("single_rsp_z", W'(rsp_z), W'(v.z));
        @(negedge clk);
        check("single_busy_idle", W'(busy), W'(0));
        tick();
    endtask

    task automatic run_steps(input int first, input int n);
        for (int s = first; s < first + n; s++) begin
            randomize_ops();
            req_vld  = steps[s].vld;
            req_last = steps[s].last;
            @(negedge clk);
            check($sformatf("step%0d_rdy", s), W'(req_rdy), W'(steps[s].rdy));
            tick();
        end
        req_vld  = '0;
        req_last = '1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic saw_rsp, saw_err;
        s_rst_n     = 1'b0;
        req_vld     = '0;
        req_last    = '1;
        req_a       = '0;
        req_b       = '0;
        inj_avail   = 1'b0;
        inj_z       = '0;
        err_allowed = 1'b0;

        vecs[0] = '{id: 2'd2, a: 64'd3, b: 64'd5, z: 128'd15};
        vecs[1] = '{id: 2'd0, a: 64'd0, b: 64'h1234, z: 128'd0};
        vecs[2] = '{id: 2'd1, a: 64'd1, b: 64'hDEADBEEF_CAFEF00D, z: 128'hDEADBEEF_CAFEF00D};
        vecs[3] = '{id: 2'd3, a: '1, b: '1, z: 128'hFFFFFFFF_FFFFFFFE_00000000_00000001};
        vecs[4] = '{id: 2'd2, a: 64'h1_0000_0000, b: 64'h1_0000_0000, z: 128'h1_00000000_00000000};
        vecs[5] = '{id: 2'd0, a: '1, b: 64'd2, z: 128'h1_FFFFFFFF_FFFFFFFE};

        // burst from 1 with 0 and 3 waiting (ptr forced to 0 by step 0)
        steps[0]  = '{vld: 4'b0001, last: 4'b1111, rdy: 4'b0001};
        steps[1]  = '{vld: 4'b1011, last: 4'b1101, rdy: 4'b0010};
        steps[2]  = '{vld: 4'b1011, last: 4'b1101, rdy: 4'b0010};
        steps[3]  = '{vld: 4'b1011, last: 4'b1111, rdy: 4'b0010};
        steps[4]  = '{vld: 4'b1001, last: 4'b1111, rdy: 4'b1000};
        steps[5]  = '{vld: 4'b0001, last: 4'b1111, rdy: 4'b0001};
        // lock on 2 with a two-cycle valid gap
        steps[6]  = '{vld: 4'b0100, last: 4'b1011, rdy: 4'b0100};
        steps[7]  = '{vld: 4'b1011, last: 4'b1111, rdy: 4'b0100};
        steps[8]  = '{vld: 4'b1011, last: 4'b1111, rdy: 4'b0100};
        steps[9]  = '{vld: 4'b1111, last: 4'b1011, rdy: 4'b0100};
        steps[10] = '{vld: 4'b1111, last: 4'b1111, rdy: 4'b0100};
        steps[11] = '{vld: 4'b1011, last: 4'b1111, rdy: 4'b1000};
        steps[12] = '{vld: 4'b0000, last: 4'b1111, rdy: 4'b0000};
        // three ops in flight before a mid-operation reset
        steps[13] = '{vld: 4'b0001, last: 4'b1111, rdy: 4'b0001};
        steps[14] = '{vld: 4'b0010, last: 4'b1111, rdy: 4'b0010};
        steps[15] = '{vld: 4'b0100, last: 4'b1111, rdy: 4'b0100};

        apply_reset();
        @(negedge clk);
        check("rst_mult_avail", W'(mult_avail), W'(0));
        check("rst_rsp_avail", W'(rsp_avail), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_err_seq", W'(err_seq), W'(0));
        check("rst_mult_a", W'(mult_a), W'(0));
        check("rst_mult_b", W'(mult_b), W'(0));
        check("rst_rsp_z", W'(rsp_z), W'(0));
        check("rst_req_rdy", W'(req_rdy), W'(0));
        tick();

        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // round robin: all valid for 8 cycles from a fresh reset
        apply_reset();
        req_last = '1;
        for (int c = 0; c < 8; c++) begin
            logic [NB_REQ-1:0] e;
            randomize_ops();
            req_vld = '1;
            e = 4'b0001 << (c % 4);
            @(negedge clk);
            check($sformatf("rr_grant%0d", c), W'(req_rdy), W'(e));
            if (c == 3) check("rr_busy", W'(busy), W'(1));
            tick();
        end
        req_vld = '0;
        drain(LAT + 3);

        run_steps(0, 13);
        drain(LAT + 3);

        // unexpected product with empty tracker
        err_allowed = 1'b1;
        inj_z       = {$urandom, $urandom, $urandom, $urandom};
        inj_avail   = 1'b1;
        tick();
        inj_avail   = 1'b0;
        @(negedge clk);
        check("err_pulse", W'(err_seq), W'(1));
        check("err_no_rsp", W'(rsp_avail), W'(0));
        tick();
        @(negedge clk);
        check("err_pulse_end", W'(err_seq), W'(0));
        tick();
        err_allowed = 1'b0;

        // reset with three ops in flight
        run_steps(13, 3);
        tick();
        check("inflight_queued", W'(exp_q.size()), W'(3));
        s_rst_n = 1'b0;
        exp_q.delete();
        tick();
        s_rst_n = 1'b1;
        saw_rsp = 1'b0;
        saw_err = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_avail != '0) saw_rsp = 1'b1;
            if (err_seq) saw_err = 1'b1;
        end
        check("rst_suppressed_rsp", W'(saw_rsp), W'(0));
        check("rst_no_err", W'(saw_err), W'(0));
        check("rst_busy_clear", W'(busy), W'(0));
        tick();
        req_vld = '1;
        @(negedge clk);
        check("rst_ptr_restored", W'(req_rdy), W'(4'b0001));
        tick();
        req_vld = '0;
        drain(LAT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
